// File: rtl/bitrev_reorder.sv
// Ping-pong reorder buffer: turns a bit-reversed FFT output frame into natural bin order.
// Two N-word banks; the writer fills one bank while the reader drains the other through a ready/valid port.
module bitrev_reorder #(
    parameter int N      = 1024,
    parameter int N_LOG2 = 10,
    parameter int DW     = 25
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sync_i,
    input  logic [N_LOG2-1:0] data_ctr_i,
    input  logic [DW-1:0]     data_re_i,
    input  logic [DW-1:0]     data_im_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [N_LOG2-1:0] ctr_o,
    output logic              last_o,
    output logic [DW-1:0]     data_re_o,
    output logic [DW-1:0]     data_im_o,
    output logic              overflow_o,
    output logic              seq_err_o
);

    typedef enum logic [1:0] {BK_EMPTY, BK_FILLING, BK_FULL, BK_DRAINING} bank_e;
    typedef enum logic [1:0] {WR_IDLE, WR_FILL, WR_DROP} wr_e;
    typedef enum logic {RD_IDLE, RD_DRAIN} rd_e;

    localparam logic [N_LOG2-1:0] C_LAST = N_LOG2'(N - 1);

    logic [2*DW-1:0]   r_mem_a [N];
    logic [2*DW-1:0]   r_mem_b [N];
    bank_e             r_bank  [2];

    wr_e               r_wr_state, w_wr_next;
    logic              r_wbank;
    logic [N_LOG2-1:0] r_wctr;

    rd_e               r_rd_state, w_rd_next;
    logic              r_rbank, r_oldest, r_rdone;
    logic [N_LOG2-1:0] r_rctr;

    logic [1:0]        w_avail, w_rel;
    logic              w_claim, w_claim_bank, w_drop_start, w_we, w_wsel;
    logic              w_complete, w_abort, w_seq_bad;
    logic              w_xfer, w_last_xfer, w_other_full, w_full_any, w_pick;
    logic              w_take, w_take_bank, w_load, w_rsel;
    logic [N_LOG2-1:0] w_raddr;
    logic [2*DW-1:0]   w_rword;

    function automatic logic [N_LOG2-1:0] f_bitrev(input logic [N_LOG2-1:0] v);
        logic [N_LOG2-1:0] r;
        for (int unsigned i = 0; i < N_LOG2; i++) r[i] = v[N_LOG2-1-i];
        return r;
    endfunction

    // ---------------- reader ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) r_rd_state <= RD_IDLE;
        else       r_rd_state <= w_rd_next;
    end

    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            RD_IDLE:  if (w_full_any) w_rd_next = RD_DRAIN;
            RD_DRAIN: if (w_last_xfer && !w_other_full) w_rd_next = RD_IDLE;
            default:  w_rd_next = RD_IDLE;
        endcase
    end

    // A pending FULL bank is fetched on the same edge the previous bank finishes, so frames abut.
    always_comb begin
        w_xfer       = valid_o && ready_i;
        w_last_xfer  = w_xfer && last_o && (r_rd_state == RD_DRAIN);
        w_rel        = {w_last_xfer && r_rbank, w_last_xfer && !r_rbank};
        w_other_full = (r_bank[~r_rbank] == BK_FULL);
        w_full_any   = (r_bank[0] == BK_FULL) || (r_bank[1] == BK_FULL);
        w_pick       = (r_bank[r_oldest] == BK_FULL) ? r_oldest : ~r_oldest;
        w_take       = 1'b0;
        w_take_bank  = r_rbank;
        w_load       = 1'b0;
        if (!rst_i) begin
            case (r_rd_state)
                RD_IDLE: begin
                    w_take      = w_full_any;
                    w_take_bank = w_pick;
                    w_load      = w_full_any;
                end
                RD_DRAIN: begin
                    w_take      = w_last_xfer && w_other_full;
                    w_take_bank = ~r_rbank;
                    w_load      = w_take || (!r_rdone && (!valid_o || ready_i));
                end
                default: ;
            endcase
        end
        w_raddr = w_take ? '0 : r_rctr;
        w_rsel  = w_take ? w_take_bank : r_rbank;
        w_rword = w_rsel ? r_mem_b[w_raddr] : r_mem_a[w_raddr];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rbank   <= 1'b0;
            r_rctr    <= '0;
            r_rdone   <= 1'b0;
            valid_o   <= 1'b0;
            last_o    <= 1'b0;
            ctr_o     <= '0;
            data_re_o <= '0;
            data_im_o <= '0;
        end else begin
            if (w_take) r_rbank <= w_take_bank;
            if (w_load) begin
                valid_o   <= 1'b1;
                ctr_o     <= w_raddr;
                last_o    <= (w_raddr == C_LAST);
                data_re_o <= w_rword[2*DW-1:DW];
                data_im_o <= w_rword[DW-1:0];
                r_rctr    <= w_raddr + 1'b1;
                r_rdone   <= (w_raddr == C_LAST);
            end else if (w_xfer) begin
                valid_o <= 1'b0;
                last_o  <= 1'b0;
            end
        end
    end

    // ---------------- writer ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) r_wr_state <= WR_IDLE;
        else       r_wr_state <= w_wr_next;
    end

    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            WR_IDLE: if (sync_i) w_wr_next = (|w_avail) ? WR_FILL : WR_DROP;
            WR_FILL, WR_DROP: if (!sync_i || r_wctr == C_LAST) w_wr_next = WR_IDLE;
            default: w_wr_next = WR_IDLE;
        endcase
    end

    // A bank released by the reader this cycle counts as EMPTY for the claim.
    always_comb begin
        w_avail[0]   = (r_bank[0] == BK_EMPTY) || w_rel[0];
        w_avail[1]   = (r_bank[1] == BK_EMPTY) || w_rel[1];
        w_claim_bank = ~w_avail[0];
        w_claim      = 1'b0;
        w_drop_start = 1'b0;
        w_we         = 1'b0;
        w_wsel       = r_wbank;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        if (!rst_i) begin
            case (r_wr_state)
                WR_IDLE: begin
                    if (sync_i && |w_avail) begin
                        w_claim = 1'b1;
                        w_we    = 1'b1;
                        w_wsel  = w_claim_bank;
                    end else if (sync_i) begin
                        w_drop_start = 1'b1;
                    end
                end
                WR_FILL: begin
                    if (sync_i) begin
                        w_we       = 1'b1;
                        w_complete = (r_wctr == C_LAST);
                    end else begin
                        w_abort = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        w_seq_bad = w_we && (data_ctr_i != f_bitrev(r_wctr));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wctr     <= '0;
            r_wbank    <= 1'b0;
            overflow_o <= 1'b0;
            seq_err_o  <= 1'b0;
        end else begin
            r_wctr <= sync_i ? r_wctr + 1'b1 : '0;
            if (w_claim)      r_wbank    <= w_claim_bank;
            if (w_drop_start) overflow_o <= 1'b1;
            if (w_seq_bad)    seq_err_o  <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_we && !w_wsel) r_mem_a[data_ctr_i] <= {data_re_i, data_im_i};
        if (w_we &&  w_wsel) r_mem_b[data_ctr_i] <= {data_re_i, data_im_i};
    end

    // ---------------- bank bookkeeping ----------------
    always_ff @(posedge clk_i) begin
        for (int unsigned b = 0; b < 2; b++) begin
            if (rst_i) begin
                r_bank[b] <= BK_EMPTY;
            end else begin
                if (w_rel[b])                           r_bank[b] <= BK_EMPTY;
                if (w_take && w_take_bank == 1'(b))     r_bank[b] <= BK_DRAINING;
                if (w_complete && r_wbank == 1'(b))     r_bank[b] <= BK_FULL;
                if (w_abort && r_wbank == 1'(b))        r_bank[b] <= BK_EMPTY;
                if (w_claim && w_claim_bank == 1'(b))   r_bank[b] <= BK_FILLING;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_oldest <= 1'b0;
        end else if (w_complete && (r_bank[~r_wbank] != BK_FULL ||
                                    (w_take && w_take_bank == ~r_wbank))) begin
            r_oldest <= r_wbank;
        end
    end

endmodule

// File: tb/tb_bitrev_reorder.sv
// Bench for bitrev_reorder (N=16, DW=8): directed frames, expected samples queued at issue,
// popped and compared by an independent output monitor.
module tb_bitrev_reorder;

    localparam int N  = 16;
    localparam int NL = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_i, sync_i, ready_i;
    logic [NL-1:0] data_ctr_i;
    logic [DW-1:0] data_re_i, data_im_i;
    logic          valid_o, last_o, overflow_o, seq_err_o;
    logic [NL-1:0] ctr_o;
    logic [DW-1:0] data_re_o, data_im_o;

    always #5 clk = ~clk;

    bitrev_reorder #(.N(N), .N_LOG2(NL), .DW(DW)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .sync_i     (sync_i),
        .data_ctr_i (data_ctr_i),
        .data_re_i  (data_re_i),
        .data_im_i  (data_im_i),
        .ready_i    (ready_i),
        .valid_o    (valid_o),
        .ctr_o      (ctr_o),
        .last_o     (last_o),
        .data_re_o  (data_re_o),
        .data_im_o  (data_im_o),
        .overflow_o (overflow_o),
        .seq_err_o  (seq_err_o)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [20:0] exp_q[$];
    bit          mon_en    = 1'b1;
    int          n_xfer    = 0;
    int          gap_cnt   = 0;
    int          max_gap   = 0;
    bit          gap_armed = 1'b0;
    bit          prev_stall = 1'b0;
    logic [21:0] cur, saved;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] rev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    // Output monitor: stall stability, inter-frame gaps, scoreboard pops.
    initial begin
        forever begin
            @(negedge clk);
            cur = {valid_o, data_re_o, data_im_o, ctr_o, last_o};
            if (rst_i || !mon_en) begin
                prev_stall = 1'b0;
                gap_armed  = 1'b0;
            end else begin
                if (prev_stall) check("stall_hold", 32'(cur), 32'(saved));
                prev_stall = valid_o && !ready_i;
                saved      = cur;
                if (gap_armed) begin
                    if (valid_o) begin
                        if (gap_cnt > max_gap) max_gap = gap_cnt;
                        gap_armed = 1'b0;
                    end else begin
                        gap_cnt++;
                    end
                end
                if (valid_o && ready_i) begin
                    n_xfer++;
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_output: got %0h expected no output", cur[20:0]);
                    end else begin
                        logic [20:0] e;
                        e = exp_q.pop_front();
                        if (cur[20:0] !== e) begin
                            n_fail++;
                            $display("FAIL out_sample {re,im,ctr,last}: got %0h expected %0h", cur[20:0], e);
                        end
                    end
                    if (last_o) begin
                        gap_armed = 1'b1;
                        gap_cnt   = 0;
                    end
                end
            end
        end
    end

    task automatic drive_sample(input logic [3:0] ctr, input logic [7:0] re, input logic [7:0] im);
        @(posedge clk); #1;
        sync_i     = 1'b1;
        data_ctr_i = ctr;
        data_re_i  = re;
        data_im_i  = im;
    endtask

    // Arrival p carries bin rev4(p): re = bin, im = 16*f + bin.
    task automatic send_frame(input int f, input int n, input bit push, input int bad);
        for (int p = 0; p < n; p++) begin
            logic [3:0] bin;
            bin = rev4(4'(p));
            drive_sample((p == bad) ? 4'd0 : bin, {4'd0, bin}, 8'(f * 16) + {4'd0, bin});
        end
        if (push)
            for (int j = 0; j < N; j++)
                exp_q.push_back({8'(j), 8'(f * 16 + j), 4'(j), 1'(j == N - 1)});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            sync_i = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !valid_o) break;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_i = 1'b1; sync_i = 1'b0; ready_i = 1'b1;
        data_ctr_i = '0; data_re_i = '0; data_im_i = '0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        exp_q.delete();
        max_gap = 0;
    endtask

    initial begin
        int n0;
        int i;
        rst_i = 1'b1; sync_i = 1'b0; ready_i = 1'b1;
        data_ctr_i = '0; data_re_i = '0; data_im_i = '0;

        // reset state
        do_reset();
        check("rst_valid",    32'(valid_o),    0);
        check("rst_last",     32'(last_o),     0);
        check("rst_ctr",      32'(ctr_o),      0);
        check("rst_re",       32'(data_re_o),  0);
        check("rst_im",       32'(data_im_o),  0);
        check("rst_overflow", 32'(overflow_o), 0);
        check("rst_seq_err",  32'(seq_err_o),  0);

        // single frame, latency
        send_frame(1, N, 1'b1, -1);
        @(posedge clk); #1;
        sync_i = 1'b0;
        check("lat_not_yet", 32'(valid_o), 0);
        @(posedge clk); #1;
        check("lat_first_valid", 32'(valid_o), 1);
        check("lat_first_ctr",   32'(ctr_o),   0);
        wait_drain("single");
        check("single_overflow", 32'(overflow_o), 0);
        check("single_seq_err",  32'(seq_err_o),  0);

        // four back-to-back frames
        do_reset();
        n0 = n_xfer;
        for (int f = 1; f <= 4; f++) send_frame(f, N, 1'b1, -1);
        idle(1);
        wait_drain("b2b");
        check("b2b_count",    32'(n_xfer - n0),  64);
        check("b2b_gap_le2",  32'(max_gap <= 2), 1);
        check("b2b_overflow", 32'(overflow_o),   0);
        check("b2b_seq_err",  32'(seq_err_o),    0);

        // 40-cycle stall from first valid: frame 3 dropped
        do_reset();
        fork
            begin
                send_frame(1, N, 1'b1, -1);
                send_frame(2, N, 1'b1, -1);
                send_frame(3, N, 1'b0, -1);
                idle(1);
            end
            begin
                for (i = 0; i < 100; i++) begin
                    @(posedge clk); #1;
                    if (valid_o) break;
                end
                check("stall_first_valid_seen", 32'(i < 100), 1);
                ready_i = 1'b0;
                repeat (40) @(posedge clk);
                #1 ready_i = 1'b1;
            end
        join
        idle(20);
        send_frame(4, N, 1'b1, -1);
        idle(1);
        wait_drain("stall");
        check("stall_overflow", 32'(overflow_o), 1);
        check("stall_seq_err",  32'(seq_err_o),  0);

        // aborted partial frame, then full frame
        do_reset();
        send_frame(5, 7, 1'b0, -1);
        idle(3);
        send_frame(6, N, 1'b1, -1);
        idle(1);
        wait_drain("abort");
        check("abort_overflow", 32'(overflow_o), 0);
        check("abort_seq_err",  32'(seq_err_o),  0);

        // reset at output sample 5
        do_reset();
        send_frame(7, N, 1'b1, -1);
        idle(1);
        for (i = 0; i < 100; i++) begin
            if (valid_o && ctr_o == 4'd5) break;
            @(posedge clk); #1;
        end
        check("midrst_sample5_seen", 32'(i < 100), 1);
        rst_i = 1'b1;
        @(posedge clk); #1;
        check("midrst_valid",    32'(valid_o),    0);
        check("midrst_ctr",      32'(ctr_o),      0);
        check("midrst_overflow", 32'(overflow_o), 0);
        check("midrst_seq_err",  32'(seq_err_o),  0);
        rst_i = 1'b0;
        exp_q.delete();
        send_frame(8, N, 1'b1, -1);
        idle(1);
        wait_drain("midrst");

        // sequence error on sample 1
        do_reset();
        mon_en = 1'b0;
        drive_sample(4'd0, 8'd0, 8'd0);
        drive_sample(4'd0, 8'd8, 8'd8);
        check("seq_ok_after_s0", 32'(seq_err_o), 0);
        for (int p = 2; p < N; p++) drive_sample(rev4(4'(p)), 8'(rev4(4'(p))), 8'd0);
        check("seq_err_set", 32'(seq_err_o), 1);
        idle(30);
        check("seq_err_sticky", 32'(seq_err_o), 1);
        wait_drain("seq");
        do_reset();
        check("seq_err_cleared", 32'(seq_err_o), 0);
        mon_en = 1'b1;

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
